// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
// MC_CTRL_LONGMUL_EN adds the MULWBHI state used by UMULL/SMULL writeback.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI,
    ALUWB, BRANCH, MULWAIT, MULWBLO
`ifdef MC_CTRL_LONGMUL_EN
    , MULWBHI
`endif
  } state_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_ORR   = 3'b011;
  localparam logic [2:0] ALU_EOR   = 3'b100;
  localparam logic [2:0] ALU_MUL   = 3'b101;
  localparam logic [2:0] ALU_UMULL = 3'b110;
  localparam logic [2:0] ALU_SMULL = 3'b111;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] MOP_MUL = 4'b1001;

  // Encoding test only; callers decide whether long multiplies are enabled.
  function automatic logic isLongMulEnc(input logic [5:0] funct);
    return (funct[4:1] == 4'b0100) || (funct[4:1] == 4'b0110);
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Instruction-field inputs and control outputs between IR/datapath and the control unit.
interface mc_control_unit_if #(parameter int ALUCTL_W = 3);

  logic [1:0]          Op;
  logic [5:0]          Funct;
  logic [3:0]          Mop;
  logic [3:0]          Rd;
  logic [1:0]          FlagW;
  logic                PCS, NextPC, RegW, MemW, IRWrite, AdrSrc;
  logic [1:0]          ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
  logic [ALUCTL_W-1:0] ALUControl;
  logic                MulStart, WrHi, Busy;

  modport master (
    output Op, Funct, Mop, Rd,
    input  FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc,
    input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc,
    input  ALUControl, MulStart, WrHi, Busy
  );

  modport slave (
    input  Op, Funct, Mop, Rd,
    output FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc,
    output ALUControl, MulStart, WrHi, Busy
  );

endinterface

// File: rtl/mc_control_unit_alu_decoder.sv
// Combinational ALUControl/FlagW decode for data-processing and multiply instructions.
// Long-multiply encodings only decode when MC_CTRL_LONGMUL_EN is defined.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTL_W = 3
) (
  input  logic                aluOp,
  input  logic                flagEn,
  input  logic [3:0]          Mop,
  input  logic [5:0]          Funct,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic [1:0]          FlagW
);

  logic [2:0] ctl;
  logic       isMul;

  assign isMul = (Mop == MOP_MUL) && !Funct[5];

  // A multiply only updates flags in the cycle its product is final.
  always_comb begin
    ctl   = ALU_ADD;
    FlagW = 2'b00;
    if (aluOp) begin
      if (isMul) begin
        ctl = ALU_MUL;
`ifdef MC_CTRL_LONGMUL_EN
        if (isLongMulEnc(Funct))
          ctl = Funct[2] ? ALU_SMULL : ALU_UMULL;
`endif
        FlagW = {Funct[0] & flagEn, 1'b0};
      end else begin
        case (Funct[4:1])
          4'b0100: ctl = ALU_ADD;
          4'b0010: ctl = ALU_SUB;
          4'b0000: ctl = ALU_AND;
          4'b1100: ctl = ALU_ORR;
          4'b0001: ctl = ALU_EOR;
          default: ctl = ALU_ADD;
        endcase
        FlagW = {Funct[0], Funct[0] & ((ctl == ALU_ADD) || (ctl == ALU_SUB))};
      end
    end
  end

  assign ALUControl = ALUCTL_W'(ctl);

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle ARM control unit: main FSM, timed multiply wait, PC and instruction decode.
// MC_CTRL_LONGMUL_EN enables UMULL/SMULL with a second (RdHi) writeback cycle.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTL_W = 3,
  parameter int MUL_LAT  = 4
) (
  input logic               clk,
  input logic               reset,
  mc_control_unit_if.slave  bus
);

  state_t     state, nextState;
  logic [3:0] cnt;
  logic       isMul, mulLast;
  logic       irWrite, nextPc, regW, memW, adrSrc, aluOp, branch;
  logic       mulStart, wrHi, busy, mulState;
  logic [1:0] resultSrc, aluSrcA, aluSrcB;

  assign isMul   = (bus.Op == OP_DP) && (bus.Mop == MOP_MUL) && !bus.Funct[5];
  assign mulLast = (cnt == 4'(MUL_LAT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= nextState;
  end

  // Counts MULWAIT cycles so the wait lasts exactly MUL_LAT cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                             cnt <= 4'd0;
    else if ((state == DECODE) && (nextState == MULWAIT))  cnt <= 4'd0;
    else if (state == MULWAIT)                             cnt <= cnt + 4'd1;
  end

  always_comb begin
    nextState = state;
    irWrite   = 1'b0;
    nextPc    = 1'b0;
    regW      = 1'b0;
    memW      = 1'b0;
    adrSrc    = 1'b0;
    aluOp     = 1'b0;
    branch    = 1'b0;
    mulStart  = 1'b0;
    wrHi      = 1'b0;
    busy      = 1'b0;
    mulState  = 1'b0;
    resultSrc = 2'b00;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    case (state)
      FETCH: begin
        irWrite = 1'b1; nextPc = 1'b1;
        aluSrcA = 2'b01; aluSrcB = 2'b10; resultSrc = 2'b10;
        nextState = DECODE;
      end
      DECODE: begin
        aluSrcA = 2'b01; aluSrcB = 2'b10; resultSrc = 2'b10;
        case (bus.Op)
          OP_MEM: nextState = MEMADR;
          OP_BR:  nextState = BRANCH;
          OP_DP: begin
            if (isMul) begin
              nextState = MULWAIT;
              mulStart  = 1'b1;
            end else if (bus.Funct[5]) nextState = EXECI;
            else                       nextState = EXECR;
          end
          default: nextState = FETCH;
        endcase
      end
      MEMADR: begin
        aluSrcB   = 2'b01;
        nextState = bus.Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD:  begin adrSrc = 1'b1; nextState = MEMWB; end
      MEMWB:  begin resultSrc = 2'b01; regW = 1'b1; nextState = FETCH; end
      MEMWR:  begin adrSrc = 1'b1; memW = 1'b1; nextState = FETCH; end
      EXECR:  begin aluOp = 1'b1; nextState = ALUWB; end
      EXECI:  begin aluSrcB = 2'b01; aluOp = 1'b1; nextState = ALUWB; end
      ALUWB:  begin regW = 1'b1; nextState = FETCH; end
      BRANCH: begin
        aluSrcA = 2'b10; aluSrcB = 2'b01; resultSrc = 2'b10; branch = 1'b1;
        nextState = FETCH;
      end
      MULWAIT: begin
        aluOp = 1'b1; busy = 1'b1; mulState = 1'b1;
        if (mulLast) nextState = MULWBLO;
      end
      MULWBLO: begin
        regW = 1'b1; mulState = 1'b1;
        nextState = FETCH;
`ifdef MC_CTRL_LONGMUL_EN
        if (isLongMulEnc(bus.Funct)) nextState = MULWBHI;
`endif
      end
`ifdef MC_CTRL_LONGMUL_EN
      MULWBHI: begin
        regW = 1'b1; wrHi = 1'b1; mulState = 1'b1;
        nextState = FETCH;
      end
`endif
      default: nextState = FETCH;
    endcase
  end

  mc_alu_decoder #(.ALUCTL_W(ALUCTL_W)) aluDec (
    .aluOp      (aluOp),
    .flagEn     (mulLast),
    .Mop        (bus.Mop),
    .Funct      (bus.Funct),
    .ALUControl (bus.ALUControl),
    .FlagW      (bus.FlagW)
  );

  // The high half of a long multiply never targets the PC.
  assign bus.PCS       = branch | (regW & (bus.Rd == 4'hF) & !wrHi);
  assign bus.NextPC    = nextPc;
  assign bus.RegW      = regW;
  assign bus.MemW      = memW;
  assign bus.IRWrite   = irWrite;
  assign bus.AdrSrc    = adrSrc;
  assign bus.ResultSrc = resultSrc;
  assign bus.ALUSrcA   = aluSrcA;
  assign bus.ALUSrcB   = aluSrcB;
  assign bus.ImmSrc    = bus.Op;
  assign bus.RegSrc    = mulState ? 2'b00 : {bus.Op == OP_MEM, bus.Op == OP_BR};
  assign bus.MulStart  = mulStart;
  assign bus.WrHi      = wrHi;
  assign bus.Busy      = busy;

endmodule
